// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process operands LSB-first,
// producing a registered WIDTH-bit sum and carry-out with a one-cycle done strobe.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   ra_q;
    logic [WIDTH-1:0]   rb_q;
    logic [WIDTH-1:0]   rs_q;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               s_d;
    logic               carry_d;

    // The single full-adder cell shared by every bit position.
    always_comb begin
        s_d     = ra_q[0] ^ rb_q[0] ^ c_q;
        carry_d = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ra_q    <= a_i;
                        rb_q    <= b_i;
                        c_q     <= cin_i;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    c_q   <= carry_d;
                    ra_q  <= {1'b0, ra_q[WIDTH-1:1]};
                    rb_q  <= {1'b0, rb_q[WIDTH-1:1]};
                    rs_q  <= {s_d, rs_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Last bit: publish the result directly, rs_q is one bit short here.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= {s_d, rs_q[WIDTH-1:1]};
                        cout_q  <= carry_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random adds plus an
// exhaustive WIDTH=2 sweep, compared against plain a+b+cin arithmetic.
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int errors = 0;
    int checks = 0;
    logic [8:0] prev8 = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
        .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .a_i(a2), .b_i(b2), .cin_i(cin2),
        .busy_o(busy2), .done_o(done2), .sum_o(sum2), .cout_o(cout2)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 addition starting at the next edge; optionally leaves start high.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit hold);
        logic [8:0] exp;
        int n;
        exp    = {1'b0, a} + {1'b0, b} + {8'd0, c};
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        @(negedge clk);
        if (!hold) start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            check("busy8_in_shift", {32'd0, busy8}, 33'd1);
            check("sum8_held", {24'd0, cout8, sum8}, {24'd0, prev8});
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            @(negedge clk);
            n++;
        end
        check("latency8", 33'(n), 33'd8);
        check("busy8_at_done", {32'd0, busy8}, 33'd0);
        check("result8", {24'd0, cout8, sum8}, {24'd0, exp});
        prev8 = exp;
        @(negedge clk);
        check("done8_one_cycle", {32'd0, done8}, 33'd0);
        check("busy8_idle", {32'd0, busy8}, 33'd0);
    endtask

    task automatic add2(input logic [1:0] a, input logic [1:0] b, input logic c);
        logic [2:0] exp;
        int n;
        exp    = {1'b0, a} + {1'b0, b} + {2'd0, c};
        a2     = a;
        b2     = b;
        cin2   = c;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        a2     = ~a;
        b2     = ~b;
        cin2   = ~c;
        n = 0;
        while (done2 !== 1'b1 && n < 10) begin
            check("busy2_in_shift", {32'd0, busy2}, 33'd1);
            @(negedge clk);
            n++;
        end
        check("latency2", 33'(n), 33'd2);
        check("result2", {30'd0, cout2, sum2}, {30'd0, exp});
        @(negedge clk);
        check("done2_one_cycle", {32'd0, done2}, 33'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("reset_busy", {32'd0, busy8}, 33'd0);
        check("reset_done", {32'd0, done8}, 33'd0);
        check("reset_result", {24'd0, cout8, sum8}, 33'd0);
        @(negedge clk);
        rst = 1'b0;

        add8(8'h5A, 8'h3C, 1'b0, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 1'b0);
        add8(8'hFF, 8'hFF, 1'b1, 1'b0);
        add8(8'h00, 8'h00, 1'b0, 1'b0);

        // start held high: back-to-back acceptances every 10 cycles
        add8(8'h12, 8'h34, 1'b1, 1'b1);
        add8(8'h80, 8'h80, 1'b0, 1'b1);
        add8(8'hA5, 8'h5B, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++)
            add8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

        // reset in the middle of a SHIFT
        a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("busy8_before_abort", {32'd0, busy8}, 33'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {32'd0, busy8}, 33'd0);
        check("abort_done", {32'd0, done8}, 33'd0);
        check("abort_result", {24'd0, cout8, sum8}, 33'd0);
        prev8 = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {31'd0, busy8, done8}, 33'd0);
        end
        add8(8'hC3, 8'h7E, 1'b1, 1'b0);

        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            add2(v[4:3], v[2:1], v[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that produces a WIDTH-bit sum by passing one bit position per clock through a single full-adder cell and a registered carry. It sits next to the combinational full-adder cell in the adder family. It takes parallel operands from an upstream register, sequences them LSB-first through the cell, and presents a registered parallel sum with a one-cycle completion strobe downstream. It trades latency for area against the parallel ripple adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle strobe: sum/cout just updated.
- sum  output  WIDTH  registered result of a+b+cin (mod 2^WIDTH).
- cout  output  1  registered carry out of bit WIDTH-1.

## Operation
- One clock; reset is asynchronous and active-high.
- Internal state:
  - operand shift registers ra and rb (WIDTH each);
  - partial-sum shift register rs (WIDTH);
  - carry flop c;
  - bit counter cnt, ceil(log2(WIDTH)) bits;
  - FSM with states IDLE, SHIFT, DONE.
- IDLE: when start=1 at an edge:
  - ra<=a, rb<=b, c<=cin, cnt<=0;
  - go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, each edge:
  - s = ra[0]^rb[0]^c.
  - c <= ra[0]&rb[0] | ra[0]&c | rb[0]&c.
  - ra, rb shift right by 1 (MSB filled with 0).
  - rs shifts right with s inserted at MSB.
  - cnt <= cnt+1.
- Exit from SHIFT: on the edge where cnt==WIDTH-1, the final bit is processed, then:
  - sum <= {s, rs[WIDTH-1:1]};
  - cout <= carry computed from that bit;
  - go to DONE.
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- Outputs:
  - busy = (state==SHIFT);
  - done = (state==DONE).
  - Both are decoded from registered state, so they are glitch-free and registered-equivalent.
- sum/cout change only on the edge entering DONE. They hold their value through IDLE and the next SHIFT until the next completion.
- Arithmetic: {cout,sum} == a + b + cin, computed on the values captured at acceptance, in WIDTH+1-bit unsigned arithmetic.
- Changes on a, b, cin after acceptance have no effect on the result in progress.
- start is ignored in SHIFT and DONE; it is not queued.

## Timing
- Reset (asynchronous assert, any time):
  - state=IDLE; busy=0, done=0, sum=0, cout=0;
  - ra=rb=rs=0, c=0, cnt=0.
  - Takes effect without waiting for a clock edge.
- Reset mid-operation aborts the addition: no done pulse, sum/cout forced to 0.
- Release: the first edge with rst=0 may accept start.
- Latency, with start accepted at edge E0:
  - busy=1 after E0 through E_WIDTH (WIDTH cycles);
  - done=1 and sum/cout valid after E_WIDTH, for one cycle;
  - IDLE after E_WIDTH+1.
- Minimum issue interval: WIDTH+2 cycles. With start held high continuously, acceptances occur at E0, E_WIDTH+2, E_2(WIDTH+2), ...
- busy and done are never high simultaneously.
- done is high for exactly one cycle per accepted start.
- cnt rolls over only under reset or acceptance; no wrap occurs in normal flow.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed at E0 -> busy=1 for 8 cycles; done at E8 with sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Sum must hold 0x00 during the second SHIFT.
- WIDTH=8, start held high, a/b changed every cycle -> results match the operands present at E0, E10, E20; done exactly at E8, E18, E28.
- WIDTH=8, start at E0, rst asserted between E4 and E5 -> busy, done, sum, cout drop to 0 immediately; no done. A new start after release completes correctly.
- WIDTH=2, exhaustive over all 32 {a,b,cin} -> {cout,sum}==a+b+cin for each; done exactly 2 cycles after each acceptance.
- start asserted during SHIFT and during DONE -> ignored; exactly one done per accepted start.
